// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the MEM stage. It serialises the two requesters (data has priority, and a
// streak limit keeps fetch from starving), drives the memory port, returns read
// data with a one-cycle ack and raises pipeline stall requests.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   if_req/if_addr -> if_rdata/if_ack fetch requester (low 32 bits returned)
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack  data requester
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready  memory port
//   stall_if, stall_mem              combinational stall requests
//   timeout_err                      sticky watchdog error
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog.
// Without it BUSY waits for mem_ready indefinitely and timeout_err is 0.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              timeout_err
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic                own;     // 0 = fetch, 1 = data
  logic [STREAK_W-1:0] streak;

  logic              grant_d_c;
  logic              grant_f_c;
  logic              tmo_hit_c;
  logic [DATA_W-1:0] rdata_c;

  // Data wins unless it has already been granted MAX_D_STREAK times in a row
  // while fetch was waiting.
  assign grant_d_c = d_req & (~if_req | (streak != STREAK_W'(MAX_D_STREAK)));
  assign grant_f_c = if_req & ~grant_d_c;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts BUSY cycles; held at zero elsewhere so each BUSY entry starts fresh.
  always_ff @(posedge clk) begin
    if (!reset_n)           tmo_cnt <= '0;
    else if (state != BUSY) tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit_c = ~mem_ready & (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign rdata_c   = mem_ready ? mem_rdata : '0;

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset_n)                        timeout_err <= 1'b0;
    else if (state == BUSY && tmo_hit_c) timeout_err <= 1'b1;
  end
`else
  assign tmo_hit_c   = 1'b0;
  assign rdata_c     = mem_rdata;
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM; all port outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      own       <= 1'b0;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d_c) begin
            own       <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= BUSY;
            // A data grant with fetch waiting implies streak < MAX, so the
            // increment saturates naturally at MAX_D_STREAK.
            streak    <= if_req ? streak + STREAK_W'(1) : '0;
          end else if (grant_f_c) begin
            own       <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= BUSY;
            streak    <= '0;
          end
        end
        BUSY: begin
          if (mem_ready || tmo_hit_c) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
            if (own) begin
              d_ack <= 1'b1;
              // Stores leave the last load data in place.
              if (!mem_we) d_rdata <= rdata_c;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= rdata_c[31:0];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;

  int errors;
  int checks;

  mem_port_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: mem_req=%b mem_we=%b expected 0 0", mem_req, mem_we);
    end
    checks++;
    if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: mem_addr=%h mem_wdata=%h expected 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (if_ack !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_acks: if_ack=%b d_ack=%b expected 0 0", if_ack, d_ack);
    end
    checks++;
    if (if_rdata !== 32'h0 || d_rdata !== 64'h0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: if_rdata=%h d_rdata=%h timeout_err=%b expected 0 0 0",
               if_rdata, d_rdata, timeout_err);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    if_req  = 1'b1;
    if_addr = 64'h100;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h100 || mem_we !== 1'b0 || stall_if !== 1'b1) begin
      errors++;
      $display("FAIL fetch_issue: mem_req=%b mem_addr=%h mem_we=%b stall_if=%b expected 1 100 0 1",
               mem_req, mem_addr, mem_we, stall_if);
    end
    mem_ready = 1'b1;
    mem_rdata = 64'h00000000_00A00093;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h00A00093 || mem_req !== 1'b0 || stall_if !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack: if_ack=%b if_rdata=%h mem_req=%b stall_if=%b expected 1 00a00093 0 0",
               if_ack, if_rdata, mem_req, stall_if);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack_pulse: if_ack=%b d_ack=%b expected 0 0", if_ack, d_ack);
    end
  endtask

  task automatic test_load();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h3000;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h3000 || stall_mem !== 1'b1) begin
      errors++;
      $display("FAIL load_issue: mem_req=%b mem_we=%b mem_addr=%h stall_mem=%b expected 1 0 3000 1",
               mem_req, mem_we, mem_addr, stall_mem);
    end
    mem_ready = 1'b1;
    mem_rdata = 64'h11223344_55667788;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 64'h11223344_55667788 || if_ack !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL load_ack: d_ack=%b d_rdata=%h if_ack=%b stall_mem=%b expected 1 1122334455667788 0 0",
               d_ack, d_rdata, if_ack, stall_mem);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    int acks;
    acks    = 0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h2000;
    d_wdata = 64'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h2000 ||
          mem_wdata !== 64'hDEADBEEF || d_ack !== 1'b0) begin
        errors++;
        $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wdata=%h d_ack=%b expected 1 1 2000 deadbeef 0",
                 i, mem_req, mem_we, mem_addr, mem_wdata, d_ack);
      end
      if (i == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if (d_ack === 1'b1) acks++;
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 64'h11223344_55667788) begin
      errors++;
      $display("FAIL store_ack: d_ack=%b d_rdata=%h expected 1 1122334455667788", d_ack, d_rdata);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_single_ack: acks=%0d mem_req=%b expected 1 0", acks, mem_req);
    end
  endtask

  // Both requesters held; zero-wait memory answers one cycle after mem_req.
  task automatic test_arbitration();
    logic [9:0] exp_d;
    int grants;
    int last_cyc;
    exp_d    = 10'b1111011110;  // index 9 is the first grant: D,D,D,D,F,D,D,D,D,F
    grants   = 0;
    last_cyc = 0;
    if_req   = 1'b1;
    if_addr  = 64'h400;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = 64'h800;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      checks++;
      if (stall_if !== ~if_ack) begin
        errors++;
        $display("FAIL arb_stall_if cyc %0d: stall_if=%b expected %b", cyc, stall_if, ~if_ack);
      end
      if (grants == 10 && (if_ack === 1'b1 || d_ack === 1'b1)) begin
        if_req = 1'b0;
        d_req  = 1'b0;
        break;
      end
      if (mem_req === 1'b1 && mem_ready === 1'b0) begin
        checks++;
        if ((mem_addr === 64'h800) !== exp_d[9 - grants]) begin
          errors++;
          $display("FAIL arb_order grant %0d: data=%b expected %b", grants,
                   (mem_addr === 64'h800), exp_d[9 - grants]);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL arb_spacing grant %0d: gap=%0d expected 3", grants, cyc - last_cyc);
          end
        end
        last_cyc  = cyc;
        grants++;
        mem_ready = 1'b1;
        mem_rdata = 64'h0000_0000_0000_1234;
      end else begin
        mem_ready = 1'b0;
      end
    end
    mem_ready = 1'b0;
    checks++;
    if (grants != 10 || if_req !== 1'b0) begin
      errors++;
      $display("FAIL arb_complete: grants=%0d expected 10 within budget", grants);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_busy();
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 64'h5000;
    d_wdata = 64'h55;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rbusy_issue: mem_req=%b expected 1", mem_req);
    end
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0 ||
        d_ack !== 1'b0 || d_rdata !== 64'h0 || if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rbusy_state: req=%b we=%b addr=%h wdata=%h d_ack=%b d_rdata=%h if_rdata=%h expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, d_ack, d_rdata, if_rdata);
    end
    d_req     = 1'b0;
    d_we      = 1'b0;
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b0 || if_ack !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rbusy_no_ack: d_ack=%b if_ack=%b mem_req=%b expected 0 0 0", d_ack, if_ack, mem_req);
    end
  endtask

  task automatic test_no_timeout();
    int low_req;
    int acks;
    low_req = 0;
    acks    = 0;
    if_req  = 1'b1;
    if_addr = 64'h600;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1) low_req++;
      if (if_ack === 1'b1) acks++;
    end
    checks++;
    if (low_req != 0 || acks != 0 || mem_req !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: low_cycles=%0d acks=%0d mem_req=%b timeout_err=%b expected 0 0 1 0",
               low_req, acks, mem_req, timeout_err);
    end
    mem_ready = 1'b1;
    mem_rdata = 64'hCAFE0000_00000013;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h00000013) begin
      errors++;
      $display("FAIL late_fetch_ack: if_ack=%b if_rdata=%h expected 1 00000013", if_ack, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset_n   = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_arbitration();
    test_reset_busy();
    test_no_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
